gauss_kernel_bank: RTL and testbench
====================================

// Module: gauss_kernel_bank
// PURPOSE
//  Parametrised, runtime-loadable KSIZE x KSIZE convolution-coefficient store. It is the
//  successor to the fixed 5x5 Gaussian kernel ROM. Double-buffered: a new kernel is
//  streamed into a shadow bank while the active bank serves random reads and raster-order
//  streaming to the filter datapath. A commit swaps the two banks atomically.
// PARAMETERS
//  KSIZE  5  kernel edge length (2..15); index width IW = $clog2(KSIZE)
//  CW     8  coefficient width, unsigned
//  NC = KSIZE*KSIZE (localparam); SW = CW+$clog2(NC) (localparam, sum width)
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  rst_n      in   1      synchronous reset, active low
//  ld_valid   in   1      load beat valid (raster order: row MX, then column MY)
//  ld_data    in   CW     load coefficient
//  ld_ready   out  1      shadow bank accepting beats
//  ld_done    out  1      shadow bank holds NC beats, awaiting commit
//  commit     in   1      pulse: make the shadow bank active
//  rd_v       in   1      random-read request
//  MX1, MY1   in   IW     random-read row / column
//  gauss_data out  CW     random-read result
//  rd_ok      out  1      gauss_data valid
//  st_start   in   1      pulse: stream the active kernel
//  st_valid   out  1      stream beat valid
//  st_data    out  CW     stream coefficient
//  st_last    out  1      final beat (index NC-1)
//  st_ready   in   1      downstream accepts the beat
//  busy       out  1      stream in progress or commit pending
//  coef_sum   out  SW     sum of active coefficients (only with KERNEL_SUM_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): active bank = identity kernel (centre [KSIZE/2][KSIZE/2]=1,
//   all other entries 0). Shadow bank cleared, load count 0, FSM IDLE.
//   Output reset values: ld_ready=1, ld_done=0, gauss_data=0, rd_ok=0, st_valid=0,
//   st_data=0, st_last=0, busy=0, coef_sum=1.
//  Load: a beat is accepted when ld_valid&ld_ready and writes shadow[cnt]; cnt then
//   increments. After beat NC-1: ld_done=1 and ld_ready=0 (next cycle) until commit.
//   Beats offered while ld_ready=0 are dropped.
//  Commit: accepted only when ld_done=1; otherwise ignored (no effect, no error).
//   When accepted in IDLE, the bank select toggles at that edge. ld_done clears,
//   cnt returns to 0 and ld_ready=1 on the next cycle.
//   When accepted in STREAM, the commit is held pending (busy=1, ld_ready stays 0) and
//   the toggle happens on the edge of the st_last handshake.
//  Random read: registered, latency 1. rd_v at edge N gives gauss_data/rd_ok at N+1.
//   Data comes from the bank active before edge N, so a same-edge commit returns the
//   old value. If MX1>=KSIZE or MY1>=KSIZE: gauss_data=0, rd_ok=0.
//   When rd_v=0: rd_ok=0 and gauss_data holds its previous value.
//  Stream FSM: IDLE -> STREAM when st_start is sampled in IDLE. st_start during STREAM
//   is ignored. In STREAM, st_valid=1 with beat k (k=0..NC-1, raster order).
//   Beat k is registered: the first beat appears 1 cycle after st_start.
//   Beat k advances only on st_valid&st_ready. st_data/st_last hold stable while
//   st_ready=0. On the st_last handshake: return to IDLE, st_valid=0, apply any
//   pending commit. The stream always reads the bank active at st_start.
//  Simultaneous commit+st_start in IDLE: the commit applies first; the stream emits
//   the new kernel.
//  Reset mid-load or mid-stream: aborts immediately to reset state; partial shadow
//   data is discarded.
// CONFIGURATION
//  KERNEL_SUM_EN defined: a shadow accumulator adds each accepted beat (SW bits, no
//   overflow possible). coef_sum takes the shadow sum on the same edge as the bank
//   toggle. The shadow accumulator clears when the toggle occurs. Reset value 1.
//  KERNEL_SUM_EN undefined: the coef_sum port and the accumulator are absent.
//   All other behaviour is identical.
// TESTING (KSIZE=5, CW=8)
//  Reset, rd_v with (2,2) then (0,0) -> gauss_data 1 then 0; rd_ok=1 each cycle after.
//  Load 25 beats {4,9,12,9,4, 5,12,15,12,5, 2,4,5,4,2, 4,9,12,9,4, 2,4,5,4,2}, commit
//   -> read (1,2)=15. With KERNEL_SUM_EN: coef_sum=159. The 26th beat before commit
//   is dropped.
//  st_start, st_ready toggled 1,0,1,0...
//   -> 25 beats in raster order, data stable during stalls, st_last only on beat 24.
//  Commit issued on stream beat 3 -> remaining beats still the old kernel; busy=1
//   until st_last; reads switch to the new kernel immediately after.
//  rd_v with MX1=5 -> rd_ok=0, gauss_data=0. Commit with ld_done=0 -> reads unchanged.
//  rst_n low after 12 load beats -> ld_ready=1; the next 25 beats and a commit load
//   a clean kernel.

Source files
------------

// File: rtl/gauss_kernel_bank.sv
// gauss_kernel_bank: double-buffered, runtime-loadable KSIZE x KSIZE coefficient store.
// A kernel is streamed into the shadow bank while the active bank serves random reads
// and raster-order streaming. A commit swaps the banks atomically. If a stream is
// running, the swap is deferred until the stream's last beat is accepted.
// Optional feature: define KERNEL_SUM_EN to add the coef_sum output, which reports the
// sum of the active coefficients.
module gauss_kernel_bank #(
    parameter int KSIZE = 5,
    parameter int CW    = 8,
    localparam int IW   = $clog2(KSIZE),
    localparam int NC   = KSIZE * KSIZE,
    localparam int SW   = CW + $clog2(NC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [CW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_done,
    input  logic          commit,
    input  logic          rd_v,
    input  logic [IW-1:0] MX1,
    input  logic [IW-1:0] MY1,
    output logic [CW-1:0] gauss_data,
    output logic          rd_ok,
    input  logic          st_start,
    output logic          st_valid,
    output logic [CW-1:0] st_data,
    output logic          st_last,
    input  logic          st_ready,
    output logic          busy
`ifdef KERNEL_SUM_EN
    ,
    output logic [SW-1:0] coef_sum
`endif
);

    localparam int AW      = $clog2(NC);
    localparam int CTR_IDX = (KSIZE / 2) * KSIZE + KSIZE / 2;
    localparam logic [AW-1:0] LAST = AW'(NC - 1);
    localparam logic [IW:0]   KLIM = (IW + 1)'(KSIZE);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Two physical banks; sel chooses the active one, the other one is the shadow
    logic [CW-1:0] bank_a [NC];
    logic [CW-1:0] bank_b [NC];
    logic          sel;
    logic          pending;
    logic [0:0]    state;
    logic [AW-1:0] ld_cnt;
    logic [AW-1:0] st_idx;

    logic          ld_acc;
    logic          commit_acc;
    logic          last_hs;
    logic          do_toggle;
    logic          new_sel;
    logic          rd_in_range;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] next_idx;
    logic [CW-1:0] rd_word;
    logic [CW-1:0] next_word;
    logic [CW-1:0] first_word;

    assign ld_ready = ~ld_done;
    assign st_valid = (state == ST_STREAM);
    assign busy     = (state == ST_STREAM) || pending;

    // Handshake decode, bank swap decision and read-address generation
    always_comb begin
        ld_acc      = ld_valid && !ld_done;
        commit_acc  = commit && ld_done && !pending;
        last_hs     = (state == ST_STREAM) && st_ready && st_last;
        do_toggle   = (commit_acc && (state == ST_IDLE)) ||
                      (last_hs && (pending || commit_acc));
        new_sel     = sel ^ do_toggle;
        rd_in_range = ({1'b0, MX1} < KLIM) && ({1'b0, MY1} < KLIM);
        rd_addr     = rd_in_range ? (AW'(MX1) * AW'(KSIZE) + AW'(MY1)) : '0;
        next_idx    = (st_idx == LAST) ? '0 : st_idx + AW'(1);
        rd_word     = sel ? bank_b[rd_addr] : bank_a[rd_addr];
        next_word   = sel ? bank_b[next_idx] : bank_a[next_idx];
        first_word  = new_sel ? bank_b[0] : bank_a[0];
    end

    // Coefficient storage: reset to identity in bank A, accepted beats go to the shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                bank_a[i] <= (i == CTR_IDX) ? CW'(1) : '0;
                bank_b[i] <= '0;
            end
        end else if (ld_acc) begin
            if (sel) begin
                bank_a[ld_cnt] <= ld_data;
            end else begin
                bank_b[ld_cnt] <= ld_data;
            end
        end
    end

    // Load counter and the "shadow full, awaiting commit" flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_cnt  <= '0;
            ld_done <= 1'b0;
        end else if (do_toggle) begin
            ld_cnt  <= '0;
            ld_done <= 1'b0;
        end else if (ld_acc) begin
            if (ld_cnt == LAST) begin
                ld_done <= 1'b1;
            end else begin
                ld_cnt <= ld_cnt + AW'(1);
            end
        end
    end

    // Bank select and the deferred commit held while a stream is running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel     <= 1'b0;
            pending <= 1'b0;
        end else begin
            sel <= new_sel;
            if (do_toggle) begin
                pending <= 1'b0;
            end else if (commit_acc && (state == ST_STREAM)) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered random read from the bank that was active before this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gauss_data <= '0;
            rd_ok      <= 1'b0;
        end else if (rd_v) begin
            gauss_data <= rd_in_range ? rd_word : '0;
            rd_ok      <= rd_in_range;
        end else begin
            rd_ok <= 1'b0;
        end
    end

    // Stream FSM: beat 0 is taken from the bank active after any same-edge commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            st_idx  <= '0;
            st_data <= '0;
            st_last <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (st_start) begin
                state   <= ST_STREAM;
                st_idx  <= '0;
                st_data <= first_word;
                st_last <= 1'b0;
            end
        end else if (st_ready) begin
            if (st_last) begin
                state   <= ST_IDLE;
                st_idx  <= '0;
                st_data <= '0;
                st_last <= 1'b0;
            end else begin
                st_idx  <= next_idx;
                st_data <= next_word;
                st_last <= (next_idx == LAST);
            end
        end
    end

`ifdef KERNEL_SUM_EN
    logic [SW-1:0] shadow_sum;

    // Running sum of the shadow bank, published to coef_sum when the banks swap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_sum <= '0;
            coef_sum   <= SW'(1);
        end else if (do_toggle) begin
            coef_sum   <= shadow_sum;
            shadow_sum <= '0;
        end else if (ld_acc) begin
            shadow_sum <= shadow_sum + SW'(ld_data);
        end
    end
`endif

endmodule

// File: tb/tb_gauss_kernel_bank.sv
// tb_gauss_kernel_bank: self-checking bench for gauss_kernel_bank (KSIZE=5, CW=8).
// A kernel-level reference model (active kernel array, shadow queue, stream snapshot)
// predicts every output each cycle; table-driven and hand-written sequences add
// explicit expectations. Honours KERNEL_SUM_EN for the coef_sum port.
module tb_gauss_kernel_bank;

    localparam int KS  = 5;
    localparam int CWD = 8;
    localparam int IW  = $clog2(KS);
    localparam int NC  = KS * KS;
    localparam int SW  = CWD + $clog2(NC);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ld_valid;
    logic [CWD-1:0] ld_data;
    logic           ld_ready;
    logic           ld_done;
    logic           commit;
    logic           rd_v;
    logic [IW-1:0]  MX1;
    logic [IW-1:0]  MY1;
    logic [CWD-1:0] gauss_data;
    logic           rd_ok;
    logic           st_start;
    logic           st_valid;
    logic [CWD-1:0] st_data;
    logic           st_last;
    logic           st_ready;
    logic           busy;
`ifdef KERNEL_SUM_EN
    logic [SW-1:0]  coef_sum;
`endif

    gauss_kernel_bank #(.KSIZE(KS), .CW(CWD)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
        .commit(commit),
        .rd_v(rd_v), .MX1(MX1), .MY1(MY1), .gauss_data(gauss_data), .rd_ok(rd_ok),
        .st_start(st_start), .st_valid(st_valid), .st_data(st_data), .st_last(st_last),
        .st_ready(st_ready), .busy(busy)
`ifdef KERNEL_SUM_EN
        , .coef_sum(coef_sum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int act [NC];
    int snap [NC];
    int sh_q [$];
    bit m_stream;
    bit m_pend;
    int m_beat;
    int m_gauss;
    bit m_rd_ok;
    int m_sum;

    int gk [NC] = '{4, 9, 12, 9, 4, 5, 12, 15, 12, 5, 2, 4, 5, 4, 2,
                    4, 9, 12, 9, 4, 2, 4, 5, 4, 2};
    int rk [NC];
    int recv [NC];

    typedef struct {
        bit rdv;
        int mx;
        int my;
        int exp_data;
        bit exp_ok;
    } rd_vec_t;

    rd_vec_t rd_table [7];

    function automatic void check(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) act[i] = (i == (KS / 2) * KS + KS / 2) ? 1 : 0;
        sh_q.delete();
        m_stream = 0;
        m_pend   = 0;
        m_beat   = 0;
        m_gauss  = 0;
        m_rd_ok  = 0;
        m_sum    = 1;
    endfunction

    // Predicts the effect of the coming clock edge from the current inputs
    function automatic void model_edge();
        bit full;
        bit was_stream;
        bit last_hs;
        bit do_commit;
        int total;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (rd_v) begin
            if (int'(MX1) < KS && int'(MY1) < KS) begin
                m_rd_ok = 1;
                m_gauss = act[int'(MX1) * KS + int'(MY1)];
            end else begin
                m_rd_ok = 0;
                m_gauss = 0;
            end
        end else begin
            m_rd_ok = 0;
        end
        full       = (sh_q.size() == NC);
        was_stream = m_stream;
        last_hs    = m_stream && st_ready && (m_beat == NC - 1);
        do_commit  = 0;
        if (commit && full && !m_pend) begin
            if (m_stream && !last_hs) m_pend = 1;
            else do_commit = 1;
        end
        if (last_hs && m_pend) do_commit = 1;
        if (m_stream && st_ready) begin
            if (m_beat == NC - 1) m_stream = 0;
            else m_beat++;
        end
        if (do_commit) begin
            total = 0;
            for (int i = 0; i < NC; i++) begin
                act[i] = sh_q[i];
                total += sh_q[i];
            end
            m_sum = total;
            sh_q.delete();
            m_pend = 0;
        end
        if (!was_stream && st_start) begin
            for (int i = 0; i < NC; i++) snap[i] = act[i];
            m_stream = 1;
            m_beat   = 0;
        end
        if (ld_valid && !full) sh_q.push_back(int'(ld_data));
    endfunction

    task automatic checkOutput();
        check("ld_ready", int'(ld_ready), (sh_q.size() != NC) ? 1 : 0);
        check("ld_done", int'(ld_done), (sh_q.size() == NC) ? 1 : 0);
        check("rd_ok", int'(rd_ok), int'(m_rd_ok));
        check("gauss_data", int'(gauss_data), m_gauss);
        check("busy", int'(busy), (m_stream || m_pend) ? 1 : 0);
        check("st_valid", int'(st_valid), int'(m_stream));
        check("st_data", int'(st_data), m_stream ? snap[m_beat] : 0);
        check("st_last", int'(st_last), (m_stream && m_beat == NC - 1) ? 1 : 0);
`ifdef KERNEL_SUM_EN
        check("coef_sum", int'(coef_sum), m_sum);
`endif
    endtask

    // One clock cycle with the currently driven inputs, then model comparison
    task automatic applyStimulus();
        model_edge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle_inputs();
        ld_valid = 0;
        ld_data  = '0;
        commit   = 0;
        rd_v     = 0;
        MX1      = '0;
        MY1      = '0;
        st_start = 0;
        st_ready = 1;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        applyStimulus();
        applyStimulus();
        rst_n = 1;
    endtask

    task automatic load_beat(input int d);
        ld_valid = 1;
        ld_data  = CWD'(d);
        applyStimulus();
        ld_valid = 0;
    endtask

    task automatic do_commit_pulse();
        commit = 1;
        applyStimulus();
        commit = 0;
    endtask

    task automatic read_at(input int x, input int y);
        rd_v = 1;
        MX1  = IW'(x);
        MY1  = IW'(y);
        applyStimulus();
        rd_v = 0;
    endtask

    // Runs one full stream, recording accepted beats; optional commit at a beat or at start
    task automatic run_stream(input int commit_beat, input bit toggle_ready, input bit commit_at_start);
        int hs;
        int cyc;
        st_start = 1;
        commit   = commit_at_start;
        applyStimulus();
        st_start = 0;
        commit   = 0;
        hs  = 0;
        cyc = 0;
        while (st_valid && cyc < 200) begin
            st_ready = toggle_ready ? ((cyc % 2) == 0) : 1'b1;
            commit   = (hs == commit_beat);
            if (st_ready) begin
                if (hs < NC) recv[hs] = int'(st_data);
                hs++;
            end
            applyStimulus();
            cyc++;
        end
        commit   = 0;
        st_ready = 1;
        check("stream_in_budget", (cyc < 200) ? 1 : 0, 1);
        check("stream_beats", hs, NC);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        apply_reset();

        rd_table[0] = '{1, 2, 2, 1, 1};
        rd_table[1] = '{1, 0, 0, 0, 1};
        rd_table[2] = '{0, 0, 0, 0, 0};
        rd_table[3] = '{1, 5, 0, 0, 0};
        rd_table[4] = '{1, 2, 2, 1, 1};
        rd_table[5] = '{0, 3, 3, 1, 0};
        rd_table[6] = '{1, 2, 5, 0, 0};

        check("rst_ld_ready", int'(ld_ready), 1);
        check("rst_busy", int'(busy), 0);

        // Identity kernel reads after reset
        for (int i = 0; i < 7; i++) begin
            rd_v = rd_table[i].rdv;
            MX1  = IW'(rd_table[i].mx);
            MY1  = IW'(rd_table[i].my);
            applyStimulus();
            check("tbl_gauss_data", int'(gauss_data), rd_table[i].exp_data);
            check("tbl_rd_ok", int'(rd_ok), int'(rd_table[i].exp_ok));
        end
        rd_v = 0;

        // Load the Gaussian kernel, offer a 26th beat that must be dropped, commit
        for (int i = 0; i < NC; i++) load_beat(gk[i]);
        load_beat(77);
        check("full_ld_done", int'(ld_done), 1);
        check("full_ld_ready", int'(ld_ready), 0);
        do_commit_pulse();
        read_at(1, 2);
        check("read_1_2", int'(gauss_data), 15);
`ifdef KERNEL_SUM_EN
        check("coef_sum_gauss", int'(coef_sum), 159);
`endif

        // Stream with st_ready toggling 1,0,1,0...
        run_stream(-1, 1, 0);
        for (int i = 0; i < NC; i++) check("stream_toggle_data", recv[i], gk[i]);

        // Commit issued on stream beat 3: stream keeps the old kernel
        for (int i = 0; i < NC; i++) begin
            rk[i] = int'($urandom_range(0, 255));
            load_beat(rk[i]);
        end
        run_stream(3, 0, 0);
        for (int i = 0; i < NC; i++) check("stream_old_kernel", recv[i], gk[i]);
        read_at(0, 0);
        check("new_kernel_0_0", int'(gauss_data), rk[0]);
        read_at(4, 4);
        check("new_kernel_4_4", int'(gauss_data), rk[24]);

        // Out-of-range read and commit without a full shadow
        read_at(5, 0);
        check("oor_rd_ok", int'(rd_ok), 0);
        check("oor_gauss_data", int'(gauss_data), 0);
        do_commit_pulse();
        read_at(1, 2);
        check("commit_ignored", int'(gauss_data), rk[7]);

        // Commit and st_start together: stream must emit the new kernel
        for (int i = 0; i < NC; i++) load_beat(gk[i]);
        run_stream(-1, 0, 1);
        for (int i = 0; i < NC; i++) check("stream_new_kernel", recv[i], gk[i]);

        // Reset after 12 load beats, then a clean load
        for (int i = 0; i < 12; i++) load_beat(200 + i);
        apply_reset();
        check("midload_ld_ready", int'(ld_ready), 1);
        for (int i = 0; i < NC; i++) begin
            rk[i] = int'($urandom_range(0, 255));
            load_beat(rk[i]);
        end
        do_commit_pulse();
        for (int i = 0; i < NC; i++) begin
            read_at(i / KS, i % KS);
            check("clean_kernel", int'(gauss_data), rk[i]);
        end

        // Randomised traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = CWD'($urandom);
            commit   = ($urandom_range(0, 9) == 0);
            rd_v     = 1'($urandom_range(0, 1));
            MX1      = IW'($urandom_range(0, 7));
            MY1      = IW'($urandom_range(0, 7));
            st_start = ($urandom_range(0, 7) == 0);
            st_ready = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end
        rst_n = 1;
        idle_inputs();
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
